// File: rtl/rv_stream_pkg.sv
// Shared types and constants for the ready/valid stream source.
// Covers the FSM state encoding, the word-mode encodings and the Galois LFSR tap table.
package rv_stream_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic MODE_INC  = 1'b0;
   localparam logic MODE_LFSR = 1'b1;

   localparam logic [7:0]  TAPS8  = 8'hB8;
   localparam logic [15:0] TAPS16 = 16'hB400;
   localparam logic [31:0] TAPS32 = 32'hA3000000;

   // Unsupported widths fall back to the 8-bit polynomial.
   function automatic logic [31:0] lfsr_taps(input int width);
      logic [31:0] taps;
      taps = {24'd0, TAPS8};
      if (width == 16) taps = {16'd0, TAPS16};
      if (width == 32) taps = TAPS32;
      return taps;
   endfunction

endpackage

// File: rtl/rv_lfsr_step.sv
// One step of a right-shifting Galois LFSR; purely combinational.
// The tap polynomial is chosen from the package table by DATA_WIDTH.
module rv_lfsr_step
   import rv_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] data_next
);

   localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

   assign data_next = (data >> 1) ^ (data[0] ? TAPS : '0);

endmodule

// File: rtl/rv_stream_source.sv
// Ready/valid burst generator: one start pulse emits burst_len incrementing or LFSR words.
// Define RV_SRC_THROTTLE_EN to insert gap_len idle cycles between beats.
module rv_stream_source
   import rv_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8,
   parameter int GAP_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic                  mode,
   input  logic [GAP_WIDTH-1:0]  gap_len,
   input  logic                  ready_in,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  last_out,
   output logic                  busy,
   output logic                  done
);

   state_t                state, state_next;
   logic [DATA_WIDTH-1:0] data_q, data_next, lfsr_next;
   logic [LEN_WIDTH-1:0]  remaining, remaining_next;
   logic                  mode_q, mode_next;
   logic                  transfer, last_beat;

`ifdef RV_SRC_THROTTLE_EN
   logic [GAP_WIDTH-1:0]  gap_len_q, gap_len_next;
   logic [GAP_WIDTH-1:0]  gap_cnt, gap_cnt_next;
`else
   logic                  unused_gap;
   assign unused_gap = ^gap_len;
`endif

   rv_lfsr_step #(.DATA_WIDTH(DATA_WIDTH)) u_lfsr_step (
      .data      (data_q),
      .data_next (lfsr_next)
   );

   // Every output is a decode of registered state, so nothing here is combinational from inputs.
   assign valid_out = (state == SEND);
   assign last_beat = (remaining == LEN_WIDTH'(1));
   assign last_out  = valid_out & last_beat;
   assign transfer  = valid_out & ready_in;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign data_out  = data_q;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_next     = state;
      data_next      = data_q;
      remaining_next = remaining;
      mode_next      = mode_q;
`ifdef RV_SRC_THROTTLE_EN
      gap_len_next   = gap_len_q;
      gap_cnt_next   = gap_cnt;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               mode_next      = mode;
               remaining_next = burst_len;
               // An all-zero LFSR state would lock up, so it is replaced by 1.
               data_next      = (mode == MODE_LFSR && seed == '0) ? DATA_WIDTH'(1) : seed;
`ifdef RV_SRC_THROTTLE_EN
               gap_len_next   = gap_len;
`endif
               state_next     = (burst_len == '0) ? DONE : SEND;
            end
         end
         SEND: begin
            if (transfer) begin
               data_next      = (mode_q == MODE_LFSR) ? lfsr_next : data_q + DATA_WIDTH'(1);
               remaining_next = remaining - LEN_WIDTH'(1);
               if (last_beat) begin
                  state_next = DONE;
`ifdef RV_SRC_THROTTLE_EN
               end else if (gap_len_q != '0) begin
                  state_next   = GAP;
                  gap_cnt_next = gap_len_q;
`endif
               end
            end
         end
`ifdef RV_SRC_THROTTLE_EN
         GAP: begin
            if (gap_cnt <= GAP_WIDTH'(1)) begin
               state_next = SEND;
            end else begin
               gap_cnt_next = gap_cnt - GAP_WIDTH'(1);
            end
         end
`endif
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         data_q    <= '0;
         remaining <= '0;
         mode_q    <= MODE_INC;
`ifdef RV_SRC_THROTTLE_EN
         gap_len_q <= '0;
         gap_cnt   <= '0;
`endif
      end else begin
         state     <= state_next;
         data_q    <= data_next;
         remaining <= remaining_next;
         mode_q    <= mode_next;
`ifdef RV_SRC_THROTTLE_EN
         gap_len_q <= gap_len_next;
         gap_cnt   <= gap_cnt_next;
`endif
      end
   end

endmodule

// File: tb/tb_rv_stream_source.sv
// Self-checking bench for rv_stream_source: directed literal scenarios plus a random soak,
// with every cycle compared against a queue-based burst model.
module tb_rv_stream_source;
   import rv_stream_pkg::*;

   localparam int DW = 8;
   localparam int LW = 8;
   localparam int GW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] burst_len = '0;
   logic [DW-1:0] seed = '0;
   logic          mode = 1'b0;
   logic [GW-1:0] gap_len = '0;
   logic          ready_in = 1'b0;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic          last_out;
   logic          busy;
   logic          done;

   int checks = 0;
   int failures = 0;

   rv_stream_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_WIDTH(GW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .burst_len (burst_len),
      .seed      (seed),
      .mode      (mode),
      .gap_len   (gap_len),
      .ready_in  (ready_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .last_out  (last_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; the DUT samples them at the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int len, input logic [DW-1:0] s, input logic m, input int g);
      start     = 1'b1;
      burst_len = len[LW-1:0];
      seed      = s;
      mode      = m;
      gap_len   = g[GW-1:0];
      tick();
      start     = 1'b0;
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_q[$];
   bit            m_active = 1'b0;
   bit            m_done = 1'b0;
   bit            model_on = 1'b0;
   int            m_gap = 0;
   int            m_gap_len = 0;

   function automatic logic [DW-1:0] lfsr8(input logic [DW-1:0] d);
      return (d >> 1) ^ (d[0] ? 8'hB8 : 8'h00);
   endfunction

   // Compare at the falling edge, then advance the model with the inputs the DUT will sample next.
   initial begin
      logic          exp_valid;
      logic [DW-1:0] w;
      forever begin
         @(negedge clk);
         if (model_on) begin
            exp_valid = m_active && (m_gap == 0);
            check("valid_out", valid_out, exp_valid);
            check("last_out", last_out, exp_valid && (m_q.size() == 1));
            check("busy", busy, m_active || m_done);
            check("done", done, m_done);
            if (exp_valid) check("data_out", data_out, m_q[0]);
         end
         if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_done   = 1'b0;
            m_gap    = 0;
            model_on = 1'b1;
         end else if (!model_on) begin
            m_done = 1'b0;
         end else if (m_done) begin
            m_done = 1'b0;
         end else if (m_active) begin
            if (m_gap > 0) begin
               m_gap--;
            end else if (ready_in) begin
               w = m_q.pop_front();
               if (m_q.size() == 0) begin
                  m_active = 1'b0;
                  m_done   = 1'b1;
               end else begin
                  m_gap = m_gap_len;
               end
            end
         end else if (start) begin
            w = (mode == MODE_LFSR && seed == '0) ? 8'h01 : seed;
            for (int i = 0; i < int'(burst_len); i++) begin
               m_q.push_back(w);
               w = (mode == MODE_LFSR) ? lfsr8(w) : w + 8'h01;
            end
`ifdef RV_SRC_THROTTLE_EN
            m_gap_len = int'(gap_len);
`else
            m_gap_len = 0;
`endif
            m_gap = 0;
            if (burst_len == '0) m_done = 1'b1;
            else m_active = 1'b1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   logic [DW-1:0] exp1 [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
   logic [DW-1:0] exp2 [3] = '{8'hFF, 8'h00, 8'h01};
   logic [DW-1:0] exp3 [3] = '{8'h01, 8'hB8, 8'h5C};
   logic [DW-1:0] seeds3 [2] = '{8'h01, 8'h00};
`ifdef RV_SRC_THROTTLE_EN
   logic          exp6 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

   initial begin
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_valid", valid_out, 1'b0);
      check("rst_data", data_out, 8'h00);
      check("rst_last", last_out, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      tick();

      // Incrementing burst with wrap, full throughput.
      ready_in = 1'b1;
      launch(4, 8'hFE, MODE_INC, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t1_valid", valid_out, 1'b1);
         check("t1_data", data_out, exp1[i]);
         check("t1_last", last_out, i == 3);
         tick();
      end
      @(negedge clk);
      check("t1_done", done, 1'b1);
      check("t1_busy_done", busy, 1'b1);
      check("t1_valid_off", valid_out, 1'b0);
      tick();
      @(negedge clk);
      check("t1_busy_idle", busy, 1'b0);
      check("t1_done_off", done, 1'b0);
      tick();

      // Back-pressure for three cycles while beat FF is presented.
      launch(4, 8'hFE, MODE_INC, 0);
      @(negedge clk);
      check("t2_data0", data_out, 8'hFE);
      tick();
      ready_in = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t2_hold_valid", valid_out, 1'b1);
         check("t2_hold_data", data_out, 8'hFF);
         check("t2_hold_last", last_out, 1'b0);
         tick();
      end
      ready_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_data", data_out, exp2[i]);
         check("t2_last", last_out, i == 2);
         tick();
      end
      @(negedge clk);
      check("t2_done", done, 1'b1);
      repeat (2) tick();

      // LFSR bursts, including the zero-seed substitution.
      for (int s = 0; s < 2; s++) begin
         launch(3, seeds3[s], MODE_LFSR, 0);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_data", data_out, exp3[i]);
            tick();
         end
         repeat (2) tick();
      end

      // Empty burst, then a start held high through a whole burst.
      launch(0, 8'h55, MODE_INC, 0);
      @(negedge clk);
      check("t4_done", done, 1'b1);
      check("t4_valid", valid_out, 1'b0);
      tick();
      @(negedge clk);
      check("t4_done_off", done, 1'b0);
      check("t4_busy_off", busy, 1'b0);
      tick();
      start     = 1'b1;
      burst_len = 8'd3;
      seed      = 8'h10;
      mode      = MODE_INC;
      tick();
      seed      = 8'h80;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_data", data_out, 8'h10 + 8'(i));
         tick();
      end
      @(negedge clk);
      check("t4_done2", done, 1'b1);
      tick();
      start = 1'b0;
      @(negedge clk);
      check("t4_busy_idle", busy, 1'b0);
      tick();
      @(negedge clk);
      check("t4_no_second", valid_out, 1'b0);
      check("t4_no_second_busy", busy, 1'b0);
      tick();

      // Reset during beat 2 of 5, then a clean burst.
      launch(5, 8'h20, MODE_INC, 0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("t5_valid", valid_out, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_done", done, 1'b0);
      tick();
      launch(2, 8'h40, MODE_INC, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("t5_data", data_out, 8'h40 + 8'(i));
         tick();
      end
      repeat (2) tick();

`ifdef RV_SRC_THROTTLE_EN
      // Two idle cycles between beats.
      launch(3, 8'h00, MODE_INC, 2);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("t6_valid", valid_out, exp6[i]);
         tick();
      end
      @(negedge clk);
      check("t6_done", done, 1'b1);
      repeat (2) tick();
`endif

      // Random soak: back-pressure, overlapping starts, occasional resets.
      for (int c = 0; c < 2500; c++) begin
         ready_in  = ($urandom_range(0, 9) < 7);
         start     = ($urandom_range(0, 4) == 0);
         burst_len = LW'($urandom_range(0, 9));
         seed      = DW'($urandom);
         mode      = 1'($urandom_range(0, 1));
         gap_len   = GW'($urandom_range(0, 3));
         reset     = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset    = 1'b0;
      start    = 1'b0;
      ready_in = 1'b1;
      repeat (60) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
